score_bcd_conv: RTL and testbench
=================================

SCORE_BCD_CONV -- requirements
Module: score_bcd_conv

Interface
REQ-001 The module SHALL use one clock; reset is synchronous and active-high.
REQ-002 Port clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-003 Port rst  input  1  synchronous active-high reset.
REQ-004 Port start  input  1  request to convert score_in; sampled only in IDLE.
REQ-005 Port score_in  input  7  unsigned binary total score (0..127), the 7-bit sum produced by the score adder.
REQ-006 Port busy  output  1  high while a conversion is in progress.
REQ-007 Port done  output  1  single-cycle pulse: new digits valid.
REQ-008 Port hundreds  output  4  BCD hundreds digit (0 or 1).
REQ-009 Port tens  output  4  BCD tens digit (0..9).
REQ-010 Port ones  output  4  BCD ones digit (0..9).
REQ-011 Port over99  output  1  high when the last converted score exceeded 99.

Function
REQ-012 The module SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-013 In IDLE, when start=1 at a rising edge, the module SHALL capture score_in into a 7-bit shift register, clear a 12-bit BCD scratch register and a 3-bit iteration counter, and enter SHIFT.
REQ-014 In IDLE with start=0, the state and all outputs SHALL hold.
REQ-015 Each SHIFT cycle SHALL add 3 to every scratch BCD nibble >= 5, then shift {scratch, shift register} left one bit, with the shift register MSB entering the scratch LSB (double-dabble).
REQ-016 SHIFT SHALL last exactly 7 cycles; on the edge completing the 7th iteration (counter = 6), the FSM SHALL enter DONE.
REQ-017 On that same edge, hundreds/tens/ones SHALL load from the scratch nibbles [11:8]/[7:4]/[3:0], and over99 SHALL load (captured score > 99).
REQ-018 busy SHALL be 1 in SHIFT only; done SHALL be 1 in DONE only; DONE SHALL always return to IDLE after one cycle.
REQ-019 Latency: with start captured at edge N, done SHALL be high between edges N+7 and N+8; busy SHALL be high between edges N and N+7.
REQ-020 start SHALL be ignored in SHIFT and DONE; changes on score_in after capture SHALL NOT affect the result.
REQ-021 start=1 in the first IDLE cycle after DONE SHALL be accepted; back-to-back conversions therefore occur every 9 cycles.
REQ-022 hundreds/tens/ones/over99 SHALL hold their last loaded values until the next DONE entry or reset.
REQ-023 Every input value 0..127 SHALL convert exactly; no saturation or wrap-around.

Reset
REQ-024 When rst=1 at a rising edge, the FSM SHALL go to IDLE and busy, done, hundreds, tens, ones, over99, counter, and scratch and shift registers SHALL all be 0.
REQ-025 Reset SHALL take priority over start and over any in-progress conversion; an aborted conversion SHALL produce no done pulse.
REQ-026 A start asserted in the cycle rst deasserts SHALL be accepted on the next edge (rst low).

Verification
REQ-027 Reset, then start with score_in=0 -> done 7 cycles after capture; hundreds=0, tens=0, ones=0, over99=0.
REQ-028 score_in=50 (25+25) -> 0/5/0, over99=0; score_in=85 (40+45) -> 0/8/5, over99=0.
REQ-029 score_in=100 (50+50) -> 1/0/0, over99=1; score_in=127 -> 1/2/7, over99=1; score_in=99 -> 0/9/9, over99=0.
REQ-030 Held start with score_in changed mid-conversion (85 to 3) -> first result 0/8/5; second conversion starts on the IDLE cycle after done and yields 0/0/3.
REQ-031 rst asserted on the 4th SHIFT cycle -> next cycle IDLE, all outputs 0, no done pulse; a new start of 42 then yields 0/4/2.
REQ-032 Exhaustive sweep 0..127 -> each result matches integer division/modulo by 100 and 10; busy high exactly 7 cycles and done exactly 1 cycle per conversion.

Source files
------------

// File: rtl/score_bcd_conv.sv
// score_bcd_conv: converts a 7-bit binary score (0..127) into three BCD digits
// using a sequential double-dabble (shift-and-add-3) over seven SHIFT cycles.
//
// Ports:
//   clk       system clock, all state updates on the rising edge
//   rst       synchronous active-high reset
//   start     request a conversion of score_in (sampled only in IDLE)
//   score_in  7-bit unsigned binary score
//   busy      high while the conversion is shifting
//   done      one-cycle pulse when hundreds/tens/ones/over99 are freshly loaded
//   hundreds  BCD hundreds digit (0 or 1)
//   tens      BCD tens digit
//   ones      BCD ones digit
//   over99    last converted score was greater than 99
module score_bcd_conv (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [6:0] score_in,
   output logic       busy,
   output logic       done,
   output logic [3:0] hundreds,
   output logic [3:0] tens,
   output logic [3:0] ones,
   output logic       over99
);

   typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

   state_e      state_q, state_d;
   logic [6:0]  shreg_q, shreg_d;
   logic [11:0] scratch_q, scratch_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [3:0]  hundreds_d, tens_d, ones_d;
   logic        over99_d;

   // Scratch after the add-3 correction, and after the subsequent left shift.
   logic [11:0] adj;
   logic [11:0] shifted;

   always_comb begin
      adj[11:8] = (scratch_q[11:8] >= 4'd5) ? scratch_q[11:8] + 4'd3 : scratch_q[11:8];
      adj[7:4]  = (scratch_q[7:4]  >= 4'd5) ? scratch_q[7:4]  + 4'd3 : scratch_q[7:4];
      adj[3:0]  = (scratch_q[3:0]  >= 4'd5) ? scratch_q[3:0]  + 4'd3 : scratch_q[3:0];
      shifted   = {adj[10:0], shreg_q[6]};
   end

   always_comb begin
      state_d    = state_q;
      shreg_d    = shreg_q;
      scratch_d  = scratch_q;
      cnt_d      = cnt_q;
      hundreds_d = hundreds;
      tens_d     = tens;
      ones_d     = ones;
      over99_d   = over99;
      busy       = 1'b0;
      done       = 1'b0;

      case (state_q)
         StIdle: begin
            if (start) begin
               shreg_d   = score_in;
               scratch_d = 12'd0;
               cnt_d     = 3'd0;
               state_d   = StShift;
            end
         end
         StShift: begin
            busy      = 1'b1;
            scratch_d = shifted;
            shreg_d   = {shreg_q[5:0], 1'b0};
            cnt_d     = cnt_q + 3'd1;
            if (cnt_q == 3'd6) begin
               state_d    = StDone;
               hundreds_d = shifted[11:8];
               tens_d     = shifted[7:4];
               ones_d     = shifted[3:0];
               // A nonzero hundreds digit is exactly the score > 99 case.
               over99_d   = (shifted[11:8] != 4'd0);
            end
         end
         StDone: begin
            done    = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         shreg_q   <= 7'd0;
         scratch_q <= 12'd0;
         cnt_q     <= 3'd0;
         hundreds  <= 4'd0;
         tens      <= 4'd0;
         ones      <= 4'd0;
         over99    <= 1'b0;
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         scratch_q <= scratch_d;
         cnt_q     <= cnt_d;
         hundreds  <= hundreds_d;
         tens      <= tens_d;
         ones      <= ones_d;
         over99    <= over99_d;
      end
   end

endmodule

// File: tb/tb_score_bcd_conv.sv
// tb_score_bcd_conv: self-checking bench for score_bcd_conv. Hand-written
// vector table, multi-cycle corner sequences (held start, reset abort),
// an exhaustive sweep and random conversions against an arithmetic model.
module tb_score_bcd_conv;

   logic       clk;
   logic       rst;
   logic       start;
   logic [6:0] score_in;
   logic       busy;
   logic       done;
   logic [3:0] hundreds;
   logic [3:0] tens;
   logic [3:0] ones;
   logic       over99;

   int n_checks = 0;
   int n_fail   = 0;

   score_bcd_conv dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .score_in (score_in),
      .busy     (busy),
      .done     (done),
      .hundreds (hundreds),
      .tens     (tens),
      .ones     (ones),
      .over99   (over99)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int score;
      int h;
      int t;
      int o;
      int ov;
   } vec_t;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Step to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Run one conversion: start is applied now and captured on the next edge.
   // score_in is scrambled after capture to show it no longer matters.
   task automatic do_conv(input int v, input int eh, input int et, input int eo,
                          input int eov, input string tag);
      int busy_cnt;
      int done_cnt;
      int done_at;
      int dh, dt, dd, dov;
      busy_cnt = 0;
      done_cnt = 0;
      done_at  = -1;
      dh = -1; dt = -1; dd = -1; dov = -1;
      start    = 1'b1;
      score_in = 7'(v);
      step();
      start    = 1'b0;
      score_in = 7'($urandom_range(0, 127));
      for (int k = 0; k < 20; k++) begin
         if (busy) busy_cnt++;
         if (done) begin
            done_cnt++;
            if (done_at < 0) begin
               done_at = k;
               dh = int'(hundreds); dt = int'(tens); dd = int'(ones); dov = int'(over99);
            end
         end
         step();
      end
      check({tag, ".busy_cycles"}, busy_cnt, 7);
      check({tag, ".done_cycles"}, done_cnt, 1);
      check({tag, ".done_latency"}, done_at, 7);
      check({tag, ".hundreds"}, dh, eh);
      check({tag, ".tens"}, dt, et);
      check({tag, ".ones"}, dd, eo);
      check({tag, ".over99"}, dov, eov);
      // Outputs must hold well after done.
      check({tag, ".hold"}, int'({hundreds, tens, ones}), (eh << 8) | (et << 4) | eo);
   endtask

   // Reference: plain decimal arithmetic.
   task automatic model_conv(input int v, input string tag);
      do_conv(v, v / 100, (v / 10) % 10, v % 10, (v > 99) ? 1 : 0, tag);
   endtask

   initial begin
      vec_t vecs[6];
      int   done_ks[$];
      int   dig[$];

      vecs[0] = '{score: 0,   h: 0, t: 0, o: 0, ov: 0};
      vecs[1] = '{score: 50,  h: 0, t: 5, o: 0, ov: 0};
      vecs[2] = '{score: 85,  h: 0, t: 8, o: 5, ov: 0};
      vecs[3] = '{score: 100, h: 1, t: 0, o: 0, ov: 1};
      vecs[4] = '{score: 127, h: 1, t: 2, o: 7, ov: 1};
      vecs[5] = '{score: 99,  h: 0, t: 9, o: 9, ov: 0};

      rst      = 1'b1;
      start    = 1'b0;
      score_in = 7'd0;
      repeat (3) step();
      check("reset.busy", int'(busy), 0);
      check("reset.done", int'(done), 0);
      check("reset.digits", int'({hundreds, tens, ones}), 0);
      check("reset.over99", int'(over99), 0);
      rst = 1'b0;
      step();
      check("idle.busy", int'(busy), 0);

      // Table-driven vectors.
      for (int i = 0; i < 6; i++)
         do_conv(vecs[i].score, vecs[i].h, vecs[i].t, vecs[i].o, vecs[i].ov,
                 $sformatf("vec%0d", vecs[i].score));

      // Held start, score_in changes after capture: 85 then 3 back to back.
      start    = 1'b1;
      score_in = 7'd85;
      step();
      score_in = 7'd3;
      for (int k = 0; k < 22; k++) begin
         if (k == 10) start = 1'b0;
         if (done) begin
            done_ks.push_back(k);
            dig.push_back(int'({hundreds, tens, ones}));
         end
         step();
      end
      check("held.done_count", done_ks.size(), 2);
      if (done_ks.size() == 2) begin
         check("held.first_at", done_ks[0], 7);
         check("held.first_val", dig[0], 12'h085);
         check("held.second_at", done_ks[1], 16);
         check("held.second_val", dig[1], 12'h003);
      end

      // Reset on the 4th SHIFT cycle, then start in the cycle rst drops.
      start    = 1'b1;
      score_in = 7'd99;
      step();
      start = 1'b0;
      check("abort.busy_shift1", int'(busy), 1);
      step();
      step();
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("abort.busy", int'(busy), 0);
      check("abort.done", int'(done), 0);
      check("abort.digits", int'({hundreds, tens, ones}), 0);
      check("abort.over99", int'(over99), 0);
      // One done only, at latency 7: the aborted conversion leaves no pulse.
      do_conv(42, 0, 4, 2, 0, "after_abort");

      // Exhaustive sweep.
      for (int v = 0; v < 128; v++) model_conv(v, $sformatf("sweep%0d", v));

      // Random conversions.
      for (int i = 0; i < 20; i++) model_conv(int'($urandom_range(0, 127)), $sformatf("rnd%0d", i));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
